// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg: FSM state type and chunk-counter width helper for chunked_adder.
package chunked_adder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int cnt_width(input int width, input int chunk);
      return (width / chunk > 1) ? $clog2(width / chunk) : 1;
   endfunction

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational W-bit ripple-carry adder slice.
module rca_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] c;

   assign c[0] = cin;
   assign cout = c[W];

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder, CHUNK bits per clock through one shared slice.
// Optional CHUNKED_ADDER_SUB_EN adds a sub port that inverts b at acceptance.
module chunked_adder
   import chunked_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = cnt_width(WIDTH, CHUNK);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, b_in;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d, ov_q, ov_d;
   logic             accept, run, last, c_s;
   logic [CHUNK-1:0] s_s;

`ifdef CHUNKED_ADDER_SUB_EN
   assign b_in = sub ? ~b : b;
`else
   assign b_in = b;
`endif

   assign in_ready  = (state_q == IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = ov_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

   rca_chunk #(.W(CHUNK)) u_slice (
      .a    (a_q[cnt_q*CHUNK +: CHUNK]),
      .b    (b_q[cnt_q*CHUNK +: CHUNK]),
      .cin  (carry_q),
      .sum  (s_s),
      .cout (c_s)
   );

   always_comb begin
      run     = state_q == RUN;
      last    = cnt_q == CW'(N - 1);
      state_d = accept ? RUN : (run && last) ? DONE : (state_q == DONE && out_ready) ? IDLE : state_q;
      a_d     = accept ? a : a_q;
      b_d     = accept ? b_in : b_q;
      carry_d = accept ? cin : run ? c_s : carry_q;
      cnt_d   = accept ? '0 : (run && !last) ? cnt_q + 1'b1 : cnt_q;
      cout_d  = (run && last) ? c_s : cout_q;
      ov_d    = (run && last) ? 1'b1 : (state_q == DONE && out_ready) ? 1'b0 : ov_q;
      sum_d   = sum_q;
      if (run) sum_d[cnt_q*CHUNK +: CHUNK] = s_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ov_q    <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ov_q    <= ov_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed checks for the 32/8 default build and a WIDTH=CHUNK=8 instance.
module tb_chunked_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0, cout;
   logic [31:0] a = '0, b = '0, sum;
   logic        in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, out_valid8, out_ready8 = 1'b0, cout8;
   logic [7:0]  a8 = '0, b8 = '0, sum8;
`ifdef CHUNKED_ADDER_SUB_EN
   logic        sub = 1'b0;
`endif
   int          n_run = 0, n_fail = 0;

   always #5 clk = ~clk;

   chunked_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef CHUNKED_ADDER_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
   );

   chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8),
`ifdef CHUNKED_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, wait for out_valid, check result, then complete the output handshake.
   task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tc, input logic [31:0] es, input logic ec);
      int lat;
      a = ta; b = tb_; cin = tc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_busy"}, in_ready, 0);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid && lat < 20);
      check({tag, "_lat"}, lat, 4);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_ovclr"}, out_valid, 0);
      check({tag, "_rdy"}, in_ready, 1);
   endtask

   task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic [7:0] es, input logic ec);
      int lat;
      a8 = ta; b8 = tb_; cin8 = tc; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid8 && lat < 20);
      check({tag, "_lat"}, lat, 1);
      check({tag, "_sum"}, sum8, es);
      check({tag, "_cout"}, cout8, ec);
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      check({tag, "_ovclr"}, out_valid8, 0);
   endtask

   initial begin
      logic seen;
      in_valid = 1'b1;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 1);

      run32("basic", 32'd2, 32'd3, 1'b0, 32'd5, 1'b0);
      run32("ripple", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1);
      run32("chunk1", 32'h0000_00FF, 32'd1, 1'b1, 32'h0000_0101, 1'b0);

      // Stall in DONE while new operands are offered.
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
      tick();
      a = 32'hAAAA_AAAA; b = 32'd5;
      repeat (4) tick();
      check("stall_ov", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("stall_sum", sum, 32'h2345_6789);
         check("stall_cout", cout, 0);
         check("stall_valid", out_valid, 1);
         check("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("stall_release", out_valid, 0);
      run32("after_stall", 32'd7, 32'd8, 1'b0, 32'd15, 1'b0);

      // Abort during chunk 2.
      a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      check("abort_sum", sum, 0);
      check("abort_cout", cout, 0);
      check("abort_ov", out_valid, 0);
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_ov", seen, 0);
      run32("post_abort", 32'd9, 32'd1, 1'b1, 32'd11, 1'b0);

`ifdef CHUNKED_ADDER_SUB_EN
      sub = 1'b1;
      run32("sub_pos", 32'd10, 32'd3, 1'b1, 32'd7, 1'b1);
      run32("sub_neg", 32'd3, 32'd10, 1'b1, 32'hFFFF_FFF9, 1'b0);
      sub = 1'b0;
`endif

      // Single-chunk instance: latency 1 and abort.
      run8("w8", 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1);
      a8 = 8'h55; b8 = 8'h55; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("w8_abort_ov", out_valid8, 0);
      check("w8_abort_sum", sum8, 0);
      seen = 1'b0;
      repeat (4) begin
         tick();
         if (out_valid8) seen = 1'b1;
      end
      check("w8_abort_no_ov", seen, 0);
      run8("w8_post", 8'd9, 8'd1, 1'b1, 8'd11, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
